// File: rtl/alu_rs_pkg.sv
// Shared widths, tag/opcode encodings and entry-state type for the ALU reservation station.
package alu_rs_pkg;
    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;
    localparam int OP_W   = 4;
    localparam int RS_W   = 2;

    // Tag value meaning "operand present, no pending producer".
    localparam logic [TAG_W-1:0] TAG_FREE = '1;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_AND = 4'h3,
        OP_OR  = 4'h4,
        OP_XOR = 4'h5
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ISSUED = 2'd2
    } entry_state_t;
endpackage

// File: rtl/alu_rs_prio.sv
// Lowest-index-wins priority encoder with one-hot grant and any-valid flag.
module alu_rs_prio #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] onehot,
    output logic         valid
);
    always_comb begin
        onehot = '0;
        valid  = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i] && !valid) begin
                onehot[i] = 1'b1;
                valid     = 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops until operands arrive via CDB snoop,
// issues the lowest-index ready entry each cycle, frees entries on completion report.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int unsigned ENTRIES = 2**RS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dispValid,
    input  logic [OP_W-1:0]   dispOp,
    input  logic [TAG_W-1:0]  dispTag,
    input  logic [TAG_W-1:0]  dispTag1,
    input  logic [TAG_W-1:0]  dispTag2,
    input  logic [DATA_W-1:0] dispData1,
    input  logic [DATA_W-1:0] dispData2,
    output logic              rsFull,
    input  logic              cdbValid,
    input  logic [TAG_W-1:0]  cdbTag,
    input  logic [DATA_W-1:0] cdbData,
    input  logic              finish,
    input  logic [RS_W-1:0]   finishRSNum,
    output logic              issueValid,
    output logic [OP_W-1:0]   issueOp,
    output logic [DATA_W-1:0] issueA,
    output logic [DATA_W-1:0] issueB,
    output logic [TAG_W-1:0]  issueTag,
    output logic [RS_W-1:0]   issueRSNum
);
    entry_state_t      state [ENTRIES];
    logic [OP_W-1:0]   op    [ENTRIES];
    logic [TAG_W-1:0]  dtag  [ENTRIES];
    logic [TAG_W-1:0]  tag1  [ENTRIES];
    logic [TAG_W-1:0]  tag2  [ENTRIES];
    logic [DATA_W-1:0] data1 [ENTRIES];
    logic [DATA_W-1:0] data2 [ENTRIES];

    logic [ENTRIES-1:0] free_vec, ready_vec;
    logic [ENTRIES-1:0] free_onehot, ready_onehot;
    logic               free_any, ready_any;
    logic               disp_fire;

    logic [TAG_W-1:0]  new_tag1, new_tag2;
    logic [DATA_W-1:0] new_data1, new_data2;

    always_comb begin
        free_vec  = '0;
        ready_vec = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            free_vec[i]  = (state[i] == ST_FREE);
            ready_vec[i] = (state[i] == ST_WAIT) && (tag1[i] == TAG_FREE) && (tag2[i] == TAG_FREE);
        end
    end

    alu_rs_prio #(.N(ENTRIES)) u_free_sel (
        .req    (free_vec),
        .onehot (free_onehot),
        .valid  (free_any)
    );

    alu_rs_prio #(.N(ENTRIES)) u_ready_sel (
        .req    (ready_vec),
        .onehot (ready_onehot),
        .valid  (ready_any)
    );

    assign rsFull    = !free_any;
    assign disp_fire = dispValid && free_any;

    // Dispatch bypass: a source being broadcast this cycle is captured on write.
    always_comb begin
        new_tag1  = dispTag1;
        new_data1 = dispData1;
        new_tag2  = dispTag2;
        new_data2 = dispData2;
        if (cdbValid && dispTag1 != TAG_FREE && dispTag1 == cdbTag) begin
            new_tag1  = TAG_FREE;
            new_data1 = cdbData;
        end
        if (cdbValid && dispTag2 != TAG_FREE && dispTag2 == cdbTag) begin
            new_tag2  = TAG_FREE;
            new_data2 = cdbData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                state[i] <= ST_FREE;
                op[i]    <= '0;
                dtag[i]  <= TAG_FREE;
                tag1[i]  <= TAG_FREE;
                tag2[i]  <= TAG_FREE;
                data1[i] <= '0;
                data2[i] <= '0;
            end
            issueValid <= 1'b0;
            issueOp    <= '0;
            issueA     <= '0;
            issueB     <= '0;
            issueTag   <= TAG_FREE;
            issueRSNum <= '0;
        end else begin
            issueValid <= 1'b0;
            issueOp    <= '0;
            issueA     <= '0;
            issueB     <= '0;
            issueTag   <= TAG_FREE;
            issueRSNum <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                if (state[i] == ST_WAIT && cdbValid) begin
                    if (tag1[i] != TAG_FREE && tag1[i] == cdbTag) begin
                        tag1[i]  <= TAG_FREE;
                        data1[i] <= cdbData;
                    end
                    if (tag2[i] != TAG_FREE && tag2[i] == cdbTag) begin
                        tag2[i]  <= TAG_FREE;
                        data2[i] <= cdbData;
                    end
                end
                // Issue, release and dispatch each act on a distinct start-of-cycle state.
                if (ready_onehot[i]) begin
                    state[i]   <= ST_ISSUED;
                    issueValid <= 1'b1;
                    issueOp    <= op[i];
                    issueA     <= data1[i];
                    issueB     <= data2[i];
                    issueTag   <= dtag[i];
                    issueRSNum <= RS_W'(i);
                end
                if (finish && finishRSNum == RS_W'(i) && state[i] == ST_ISSUED) begin
                    state[i] <= ST_FREE;
                end
                if (disp_fire && free_onehot[i]) begin
                    state[i] <= ST_WAIT;
                    op[i]    <= dispOp;
                    dtag[i]  <= dispTag;
                    tag1[i]  <= new_tag1;
                    tag2[i]  <= new_tag2;
                    data1[i] <= new_data1;
                    data2[i] <= new_data2;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_rs.sv
// Directed self-checking bench for alu_rs: vector table plus hand sequences for full/priority/reset.
module tb_alu_rs;
    import alu_rs_pkg::*;

    localparam logic [TAG_W-1:0] T = TAG_FREE;

    logic              clk = 1'b0;
    logic              rst;
    logic              dispValid;
    logic [OP_W-1:0]   dispOp;
    logic [TAG_W-1:0]  dispTag, dispTag1, dispTag2;
    logic [DATA_W-1:0] dispData1, dispData2;
    logic              rsFull;
    logic              cdbValid;
    logic [TAG_W-1:0]  cdbTag;
    logic [DATA_W-1:0] cdbData;
    logic              finish;
    logic [RS_W-1:0]   finishRSNum;
    logic              issueValid;
    logic [OP_W-1:0]   issueOp;
    logic [DATA_W-1:0] issueA, issueB;
    logic [TAG_W-1:0]  issueTag;
    logic [RS_W-1:0]   issueRSNum;

    int n_cmp = 0;
    int n_bad = 0;

    alu_rs #(.ENTRIES(4)) dut (
        .clk(clk), .rst(rst),
        .dispValid(dispValid), .dispOp(dispOp), .dispTag(dispTag),
        .dispTag1(dispTag1), .dispTag2(dispTag2),
        .dispData1(dispData1), .dispData2(dispData2),
        .rsFull(rsFull),
        .cdbValid(cdbValid), .cdbTag(cdbTag), .cdbData(cdbData),
        .finish(finish), .finishRSNum(finishRSNum),
        .issueValid(issueValid), .issueOp(issueOp), .issueA(issueA), .issueB(issueB),
        .issueTag(issueTag), .issueRSNum(issueRSNum)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic              dv;
        logic [OP_W-1:0]   dop;
        logic [TAG_W-1:0]  dtag, dt1, dt2;
        logic [DATA_W-1:0] dd1, dd2;
        logic              cv;
        logic [TAG_W-1:0]  ctag;
        logic [DATA_W-1:0] cdata;
        logic              fin;
        logic [RS_W-1:0]   fnum;
        logic              e_iv;
        logic [OP_W-1:0]   e_op;
        logic [DATA_W-1:0] e_a, e_b;
        logic [TAG_W-1:0]  e_tag;
        logic [RS_W-1:0]   e_num;
        logic              e_full;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dispValid = 1'b0; dispOp = '0; dispTag = '0; dispTag1 = T; dispTag2 = T;
        dispData1 = '0; dispData2 = '0;
        cdbValid = 1'b0; cdbTag = '0; cdbData = '0;
        finish = 1'b0; finishRSNum = '0;
    endtask

    task automatic disp(input logic [OP_W-1:0] o, input logic [TAG_W-1:0] tg,
                        input logic [TAG_W-1:0] t1, input logic [TAG_W-1:0] t2,
                        input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2);
        dispValid = 1'b1; dispOp = o; dispTag = tg; dispTag1 = t1; dispTag2 = t2;
        dispData1 = d1; dispData2 = d2;
    endtask

    task automatic check_issue(input string name, input logic iv, input logic [OP_W-1:0] o,
                               input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                               input logic [TAG_W-1:0] tg, input logic [RS_W-1:0] num);
        check({name, ".valid"}, 64'(issueValid), 64'(iv));
        check({name, ".op"},    64'(issueOp),    64'(o));
        check({name, ".a"},     64'(issueA),     64'(a));
        check({name, ".b"},     64'(issueB),     64'(b));
        check({name, ".tag"},   64'(issueTag),   64'(tg));
        check({name, ".num"},   64'(issueRSNum), 64'(num));
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // {dv,op,dtag,t1,t2,d1,d2, cv,ctag,cdata, fin,fnum, e_iv,e_op,e_a,e_b,e_tag,e_num,e_full}
        vecs[0] = '{1, OP_ADD, 3, T, T, 5, 7,        0, 0, 0,      0, 0,  0, 0, 0, 0, T, 0, 0};
        vecs[1] = '{0, 0, 0, T, T, 0, 0,             0, 0, 0,      0, 0,  1, OP_ADD, 5, 7, 3, 0, 0};
        vecs[2] = '{1, OP_SUB, 4, 9, T, 0, 4,        0, 0, 0,      0, 0,  0, 0, 0, 0, T, 0, 0};
        vecs[3] = '{0, 0, 0, T, T, 0, 0,             0, 0, 0,      0, 0,  0, 0, 0, 0, T, 0, 0};
        vecs[4] = '{0, 0, 0, T, T, 0, 0,             1, 9, 'h10,   0, 0,  0, 0, 0, 0, T, 0, 0};
        vecs[5] = '{0, 0, 0, T, T, 0, 0,             0, 0, 0,      1, 0,  1, OP_SUB, 'h10, 4, 4, 1, 0};
        vecs[6] = '{1, OP_XOR, 5, 6, T, 0, 'h33,     1, 6, 'h22,   0, 0,  0, 0, 0, 0, T, 0, 0};
        vecs[7] = '{0, 0, 0, T, T, 0, 0,             0, 0, 0,      1, 1,  1, OP_XOR, 'h22, 'h33, 5, 0, 0};
        vecs[8] = '{0, 0, 0, T, T, 0, 0,             0, 0, 0,      1, 0,  0, 0, 0, 0, T, 0, 0};

        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        check_issue("reset", 0, 0, 0, 0, T, 0);
        check("reset.full", 64'(rsFull), 64'(0));

        for (int k = 0; k < 9; k++) begin
            dispValid = vecs[k].dv; dispOp = vecs[k].dop; dispTag = vecs[k].dtag;
            dispTag1 = vecs[k].dt1; dispTag2 = vecs[k].dt2;
            dispData1 = vecs[k].dd1; dispData2 = vecs[k].dd2;
            cdbValid = vecs[k].cv; cdbTag = vecs[k].ctag; cdbData = vecs[k].cdata;
            finish = vecs[k].fin; finishRSNum = vecs[k].fnum;
            tick();
            check_issue($sformatf("vec%0d", k), vecs[k].e_iv, vecs[k].e_op, vecs[k].e_a,
                        vecs[k].e_b, vecs[k].e_tag, vecs[k].e_num);
            check($sformatf("vec%0d.full", k), 64'(rsFull), 64'(vecs[k].e_full));
        end

        // Full / drop / release / reuse of entry 2.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            idle();
            disp(OP_AND, TAG_W'(10 + i), TAG_W'(20 + i), T, 0, DATA_W'(i));
            tick();
            check($sformatf("fill%0d.full", i), 64'(rsFull), 64'(i == 3));
            check($sformatf("fill%0d.valid", i), 64'(issueValid), 64'(0));
        end
        idle();
        disp(OP_ADD, 50, T, T, 9, 9);
        tick();
        check("drop.full", 64'(rsFull), 64'(1));
        idle();
        tick();
        check("drop.valid", 64'(issueValid), 64'(0));
        cdbValid = 1'b1; cdbTag = 22; cdbData = 'hAA;
        tick();
        check("wake2.same_cycle", 64'(issueValid), 64'(0));
        idle();
        tick();
        check_issue("issue2", 1, OP_AND, 'hAA, 2, 12, 2);
        finish = 1'b1; finishRSNum = 2;
        tick();
        check("release.full", 64'(rsFull), 64'(0));
        check("release.valid", 64'(issueValid), 64'(0));
        idle();
        disp(OP_OR, 40, T, T, 1, 2);
        tick();
        check("reuse.full", 64'(rsFull), 64'(1));
        idle();
        tick();
        check_issue("reuse", 1, OP_OR, 1, 2, 40, 2);

        // Priority: entries 1 and 3 wait on the same producer tag.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            idle();
            disp(OP_SUB, TAG_W'(16 + i), (i == 0) ? TAG_W'(30) : (i == 2) ? TAG_W'(32) : TAG_W'(31),
                 T, 0, DATA_W'(100 + i));
            tick();
        end
        idle();
        cdbValid = 1'b1; cdbTag = 31; cdbData = 'h55;
        tick();
        check("prio.snoop_cycle", 64'(issueValid), 64'(0));
        idle();
        tick();
        check_issue("prio.first", 1, OP_SUB, 'h55, 101, 17, 1);
        tick();
        check_issue("prio.second", 1, OP_SUB, 'h55, 103, 19, 3);

        // Reset mid-operation overrides concurrent dispatch/finish/snoop.
        rst = 1'b1;
        disp(OP_ADD, 8, T, T, 1, 1);
        cdbValid = 1'b1; cdbTag = 30; cdbData = 'h77;
        finish = 1'b1; finishRSNum = 1;
        tick();
        rst = 1'b0;
        idle();
        check_issue("midreset", 0, 0, 0, 0, T, 0);
        check("midreset.full", 64'(rsFull), 64'(0));
        finish = 1'b1; finishRSNum = 3;
        tick();
        check("stale.valid", 64'(issueValid), 64'(0));
        check("stale.full", 64'(rsFull), 64'(0));
        idle();
        disp(OP_ADD, 7, T, T, 3, 4);
        tick();
        idle();
        tick();
        check_issue("post_reset", 1, OP_ADD, 3, 4, 7, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
